// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative radix-2 multiply/divide unit (RV32M operation set).
//
// Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU one bit per
// cycle on operand magnitudes, then applies the sign fix-up in the last cycle.
// An operation accepted at clock edge N presents its result after edge N+XLEN.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, b==0, a==0 or the signed-overflow divide case finish with
//   latency 1 instead of XLEN. When undefined, every op takes XLEN cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   op/a/b are valid
//   in_ready   out  unit is idle and can accept an operation
//   op         in   funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   a, b       in   rs1 / rs2 operands
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   result     out  operation result
//   busy       out  high while calculating or holding a result (EX stall)
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};

  state_t              state_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                dz_q;
  logic                early_q;
  logic [CNT_W-1:0]    cnt_q;
  // mul: {high partial product, remaining multiplier bits}
  // div: {partial remainder, dividend bits shifting into quotient}
  logic [2*XLEN-1:0]   acc_q;
  // Multiplicand/divisor magnitude, or the precomputed early-out result.
  logic [XLEN-1:0]     opb_q;
  logic [XLEN-1:0]     result_q;
  logic                out_valid_q;

  logic                a_sgn_d, b_sgn_d, sa_d, sb_d, neg_d;
  logic [XLEN-1:0]     abs_a_d, abs_b_d;
  logic                early_d;
  logic [XLEN-1:0]     early_res_d;
  logic [XLEN:0]       sum_d, shifted_d;
  logic [XLEN-1:0]     diff_d;
  logic                ge_d;
  logic [2*XLEN-1:0]   step_d, prod_d;
  logic [XLEN-1:0]     quo_d, rem_d, final_d;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Operand decode: signedness, magnitudes and sign of the final result.
  always_comb begin
    a_sgn_d = 1'b0;
    b_sgn_d = 1'b0;
    case (op)
      3'd1, 3'd4, 3'd6: begin a_sgn_d = 1'b1; b_sgn_d = 1'b1; end
      3'd2:             begin a_sgn_d = 1'b1; b_sgn_d = 1'b0; end
      default:          begin a_sgn_d = 1'b0; b_sgn_d = 1'b0; end
    endcase
    sa_d    = a_sgn_d & a[XLEN-1];
    sb_d    = b_sgn_d & b[XLEN-1];
    abs_a_d = sa_d ? -a : a;
    abs_b_d = sb_d ? -b : b;
    // Remainder takes the dividend's sign; everything else takes sa^sb.
    neg_d   = (op[2] & op[1]) ? sa_d : (sa_d ^ sb_d);
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Trivial operations whose result is known at accept time.
  always_comb begin
    logic ovf;
    ovf = ((op == 3'd4) || (op == 3'd6)) &&
          (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == ONES_X);
    early_d     = (b == ZERO_X) || (a == ZERO_X) || ovf;
    early_res_d = ZERO_X;
    case (op)
      3'd4, 3'd5: early_res_d = (b == ZERO_X) ? ONES_X : (ovf ? a : ZERO_X);
      3'd6, 3'd7: early_res_d = (b == ZERO_X) ? a : ZERO_X;
      default:    early_res_d = ZERO_X;
    endcase
  end
`else
  // Early-out disabled: every op runs the full iteration count.
  always_comb begin
    early_d     = 1'b0;
    early_res_d = ZERO_X;
  end
`endif

  // One radix-2 iteration plus the sign fix-up / result select of the last one.
  always_comb begin
    // Shift-add: add multiplicand into the high half when the multiplier LSB is set.
    sum_d     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    // Restoring division: bring in the next dividend bit and trial-subtract.
    shifted_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge_d      = (shifted_d >= {1'b0, opb_q});
    diff_d    = shifted_d[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      step_d = ge_d ? {diff_d, acc_q[XLEN-2:0], 1'b1}
                    : {shifted_d[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_d = {sum_d, acc_q[XLEN-1:1]};
    end
    prod_d = neg_q ? -step_d : step_d;
    quo_d  = step_d[XLEN-1:0];
    rem_d  = step_d[2*XLEN-1:XLEN];
    final_d = ZERO_X;
    case (op_q)
      3'd0:             final_d = prod_d[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_d = prod_d[2*XLEN-1:XLEN];
      // Divide by zero must yield all-ones regardless of the dividend sign.
      3'd4, 3'd5:       final_d = dz_q ? ONES_X : (neg_q ? -quo_d : quo_d);
      3'd6, 3'd7:       final_d = neg_q ? -rem_d : rem_d;
      default:          final_d = ZERO_X;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      early_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      opb_q       <= ZERO_X;
      result_q    <= ZERO_X;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            neg_q   <= neg_d;
            dz_q    <= (b == ZERO_X);
            early_q <= early_d;
            acc_q   <= {ZERO_X, abs_a_d};
            // Early-out parks its answer in opb_q and finishes after one CALC cycle.
            opb_q   <= early_d ? early_res_d : abs_b_d;
            cnt_q   <= early_d ? CNT_ONE : CNT_W'(XLEN);
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q <= step_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            result_q    <= early_q ? opb_q : final_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv -- self-checking bench for alu_muldiv (XLEN=32): directed
// RV32M corner cases plus randomized operations against a reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    logic [63:0]     p;
    logic            ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 32'd0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : (x / y);
      3'd6: return (y == 32'd0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
      default: return (y == 32'd0) ? x : (x % y);
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if ((y == 32'd0) || (x == 32'd0) ||
        (((f == 3'd4) || (f == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)))
      return 1;
`endif
    return 32;
  endfunction

  // Issue one op, measure latency, check result; optionally stall in DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    int lat;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_valid = 1'b1; op = f; a = x; b = y;
    @(posedge clk); #1;
    // Operand fields need not stay stable after the handshake.
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_latency(f, x, y)));
    check_eq({tag, "_result"}, result, ref_model(f, x, y));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_hold_result"}, result, ref_model(f, x, y));
      check_eq({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_result", result, 32'd0);

    // Directed corner cases.
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 0);
    run_op("remu", 3'd7, 32'hFFFF_FFFF, 32'd16, 0);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 0);
    run_op("div_neg_by0", 3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("stall10", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Reset during CALC abandons the op.
    in_valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_result", result, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 0);

    // Reset and in_valid together: the op is dropped.
    reset = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check_eq("rstvalid_busy", {31'd0, busy}, 32'd0);
    check_eq("rstvalid_in_ready", {31'd0, in_ready}, 32'd1);

    // Randomized operations, occasionally stalled.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rnd%0d_op%0d", n, rf), rf, ra, rb,
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
